// File: rtl/inv_subbytes_serial.sv
// Serial AES InvSubBytes: one byte per cycle through a single composite-field datapath.
// Latency 17 cycles start-to-done; start is ignored while busy, no output backpressure.
module inv_subbytes_serial (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // GF(2^4) uses x^4 + x + 1; the quadratic extension uses y^2 + y + LAMBDA.
  localparam logic [3:0] LAMBDA = 4'hC;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    logic [3:0] bb;
    p  = 4'h0;
    aa = a;
    bb = b;
    for (int i = 0; i < 4; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
      bb = {1'b0, bb[3:1]};
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  // a^14 == a^-1 for nonzero a, and 0 maps to 0 for free.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] gf8c_inv(input logic [7:0] a);
    logic [3:0] d;
    logic [3:0] di;
    d  = gf4_mul(gf4_sq(a[7:4]), LAMBDA) ^ gf4_mul(a[7:4], a[3:0]) ^ gf4_sq(a[3:0]);
    di = gf4_inv(d);
    return {gf4_mul(a[7:4], di), gf4_mul(a[7:4] ^ a[3:0], di)};
  endfunction

  // 8x8 GF(2) matrix, column i in bits [8i+7:8i].
  function automatic logic [7:0] lin(input logic [63:0] m, input logic [7:0] x);
    logic [7:0]  r;
    logic [7:0]  xx;
    logic [63:0] mm;
    r  = 8'h00;
    xx = x;
    mm = m;
    for (int i = 0; i < 8; i++) begin
      if (xx[0]) r = r ^ mm[7:0];
      xx = {1'b0, xx[7:1]};
      mm = {8'h00, mm[63:8]};
    end
    return r;
  endfunction

  // Basis change into the tower field: send alpha^i to beta^i, where beta is a
  // root of the AES polynomial x^8+x^4+x^3+x+1 inside GF((2^4)^2).
  function automatic logic [63:0] calc_fwd();
    logic [63:0] m;
    logic [63:0] cols;
    logic [7:0]  b;
    logic [7:0]  p;
    logic [7:0]  v;
    logic        found;
    m     = '0;
    found = 1'b0;
    for (int c = 0; c < 256; c++) begin
      b    = 8'(c);
      p    = 8'h01;
      cols = '0;
      v    = 8'h00;
      for (int i = 0; i < 9; i++) begin
        if (i < 8) cols = {p, cols[63:8]};
        if (i == 0 || i == 1 || i == 3 || i == 4 || i == 8) v = v ^ p;
        p = gf8c_mul(p, b);
      end
      if (!found && v == 8'h00) begin
        m     = cols;
        found = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [63:0] calc_inv(input logic [63:0] fwd);
    logic [63:0] m;
    logic [7:0]  tgt;
    logic [7:0]  col;
    m   = '0;
    tgt = 8'h01;
    for (int j = 0; j < 8; j++) begin
      col = 8'h00;
      for (int x = 0; x < 256; x++) begin
        if (lin(fwd, 8'(x)) == tgt) col = 8'(x);
      end
      m   = {col, m[63:8]};
      tgt = {tgt[6:0], 1'b0};
    end
    return m;
  endfunction

  localparam logic [63:0] MAP_FWD = calc_fwd();
  localparam logic [63:0] MAP_INV = calc_inv(MAP_FWD);

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [15:0][7:0] work;
  logic [3:0]       cnt;
  logic [3:0]       idx;
  logic [7:0]       sb_in;
  logic [7:0]       sb_out;
  logic             load;

  // work[15] holds byte 0 (bits 127:120).
  assign idx       = 4'd15 - cnt;
  assign sb_in     = work[idx];
  assign sb_out    = lin(MAP_INV, gf8c_inv(lin(MAP_FWD, inv_affine(sb_in))));
  assign load      = start && (state == IDLE || state == DONE);
  assign state_out = work;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      cnt  <= 4'd0;
    end else if (load) begin
      work <= state_in;
      cnt  <= 4'd0;
    end else if (state == RUN) begin
      work[idx] <= sb_out;
      cnt       <= cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_inv_subbytes_serial.sv
// Bench for inv_subbytes_serial: reference inverse S-box built from GF(2^8) arithmetic.
module tb_inv_subbytes_serial;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] state_in = '0;
  logic         busy;
  logic         done;
  logic [127:0] state_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] inv_tab [256];

  localparam logic [127:0] V26_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V26_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  inv_subbytes_serial dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in),
    .busy(busy), .done(done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward S-box by brute-force inversion plus affine map, then invert the table.
  task automatic init_model();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] apply_inv(input logic [127:0] x, input int n);
    logic [127:0] r;
    r = x;
    for (int k = 0; k < n; k++) r[127-8*k -: 8] = inv_tab[r[127-8*k -: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One full operation; state_in is scrambled after the load edge to prove it is not resampled.
  task automatic do_op(input logic [127:0] din, input string tag, input logic exp_from_model,
                       input logic [127:0] exp_const);
    int lat;
    int busy_cnt;
    logic partial_ok;
    logic [127:0] exp;
    exp = exp_from_model ? apply_inv(din, 16) : exp_const;
    @(negedge clk);
    start = 1'b1;
    state_in = din;
    @(posedge clk);
    #1 start = 1'b0;
    state_in = rnd128();
    lat = 0; busy_cnt = 0; partial_ok = 1'b1;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (done) lat = n;
      else begin
        if (busy) busy_cnt++;
        if (state_out !== apply_inv(din, n - 1)) partial_ok = 1'b0;
      end
    end
    check({tag, "_latency"}, 128'(lat), 128'd17);
    check({tag, "_result"}, state_out, exp);
    check({tag, "_sweep"}, {127'd0, partial_ok && busy_cnt == 16}, 128'd1);
  endtask

  initial begin
    logic [127:0] din;
    logic [127:0] loaded;
    int lat;
    int n;
    int last;
    int pulses;
    int extra;

    init_model();

    #1 rst = 1'b1;
    #1;
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    check("reset_state_out", state_out, 128'd0);
    start = 1'b1;
    state_in = V26_IN;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_under_reset_ignored", {127'd0, busy}, 128'd0);

    do_op(V26_IN, "fips_vector", 1'b0, V26_OUT);
    @(negedge clk);
    check("hold_after_done", state_out, V26_OUT);
    check("done_one_cycle", {126'd0, busy, done}, 128'd0);

    do_op(128'h0, "all_00", 1'b0, {16{8'h52}});
    do_op({16{8'h16}}, "all_16", 1'b0, {16{8'hff}});
    do_op({16{8'hd7}}, "all_d7", 1'b0, {16{8'h0d}});

    for (int i = 0; i < 256; i++) begin
      din = rnd128();
      din[127:120] = 8'(i);
      din[71:64]   = 8'(i) ^ 8'h5a;
      din[7:0]     = 8'(i + 8'h33);
      do_op(din, "sweep", 1'b1, 128'd0);
    end

    // Reset while cnt = 8.
    din = rnd128();
    @(negedge clk);
    start = 1'b1;
    state_in = din;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_run_partial", state_out, apply_inv(din, 8));
    #1 rst = 1'b1;
    #1;
    check("async_rst_state_out", state_out, 128'd0);
    check("async_rst_flags", {126'd0, busy, done}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", 128'(extra), 128'd0);
    do_op(V26_IN, "after_abort", 1'b0, V26_OUT);

    // start during RUN with different data is ignored.
    din = rnd128();
    @(negedge clk);
    start = 1'b1;
    state_in = din;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    state_in = ~din;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 6; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    check("run_start_latency", 128'(lat), 128'd17);
    check("run_start_result", state_out, apply_inv(din, 16));
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("run_start_no_second_op", 128'(extra), 128'd0);

    // start held high: a done every 17 cycles, each for the data loaded.
    din = rnd128();
    @(negedge clk);
    start = 1'b1;
    state_in = din;
    loaded = din;
    @(posedge clk);
    n = 0; last = 0; pulses = 0;
    while (n < 100 && pulses < 4) begin
      @(negedge clk);
      n++;
      if (done) begin
        pulses++;
        check("b2b_spacing", 128'(n - last), 128'd17);
        check("b2b_result", state_out, apply_inv(loaded, 16));
        last = n;
        loaded = state_in;
        if (pulses == 4) start = 1'b0;
      end else begin
        state_in = rnd128();
      end
    end
    start = 1'b0;
    check("b2b_pulse_count", 128'(pulses), 128'd4);
    @(negedge clk);
    check("b2b_idle_after", {126'd0, busy, done}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
